acc_cpu_control: RTL

Multi-cycle fetch/decode/execute controller for the 16-bit accumulator datapath. It owns the architectural registers (PC, MAR, MBR, IR, AC), sequences the main-memory port and the external ALU, and executes a 16-opcode single-address instruction set. It sits between the synchronous-read main memory and the combinational ALU and forms the top-level control path of the CPU.

---
 rtl/acc_cpu_control.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_control.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit accumulator CPU.
// Owns PC/MAR/MBR/IR/AC and sequences the synchronous-read memory and external ALU.
module acc_cpu_control #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              mem_we,
   input  logic [15:0]       mem_rdata,
   output logic [3:0]        alu_op,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   input  logic [15:0]       alu_result,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       ac,
   output logic [15:0]       ir,
   output logic              halted,
   output logic              instr_done
);

   typedef enum logic [3:0] {
      OP_LOAD   = 4'h0,
      OP_STORE  = 4'h1,
      OP_ADD    = 4'h2,
      OP_SUB    = 4'h3,
      OP_AND    = 4'h4,
      OP_OR     = 4'h5,
      OP_XOR    = 4'h6,
      OP_SHL    = 4'h7,
      OP_SHR    = 4'h8,
      OP_JUMP   = 4'h9,
      OP_JUMPZ  = 4'hA,
      OP_SKIPZ  = 4'hB,
      OP_SKIPNZ = 4'hC,
      OP_CLEAR  = 4'hD,
      OP_NOP    = 4'hE,
      OP_HALT   = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_FETCH_WAIT,
      S_DECODE,
      S_EXEC_READ,
      S_EXEC_WAIT,
      S_EXEC,
      S_EXEC_WRITE,
      S_HALT
   } state_e;

   state_e            state;
   logic [ADDR_W-1:0] mar;
   logic [15:0]       mbr;
   opcode_e           opcode;
   logic [ADDR_W-1:0] operand;
   logic [ADDR_W-1:0] pc_inc;
   logic              ac_zero;

   assign opcode    = opcode_e'(ir[15:12]);
   assign operand   = ADDR_W'(ir[11:0]);
   assign pc_inc    = pc + ADDR_W'(1);
   assign ac_zero   = (ac == 16'h0000);

   assign mem_addr  = (state == S_FETCH) ? pc : mar;
   assign mem_wdata = ac;
   assign alu_a     = ac;
   assign alu_b     = mbr;

   // NOTE: alu_op gets a default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      alu_op = 4'b0000;
      case (opcode)
         OP_ADD:  alu_op = 4'b0000;
         OP_SUB:  alu_op = 4'b0001;
         OP_AND:  alu_op = 4'b1000;
         OP_OR:   alu_op = 4'b1001;
         OP_XOR:  alu_op = 4'b1010;
         OP_SHL:  alu_op = 4'b0100;
         OP_SHR:  alu_op = 4'b0101;
         default: alu_op = 4'b0000;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_FETCH;
         pc         <= '0;
         mar        <= '0;
         mbr        <= '0;
         ir         <= '0;
         ac         <= '0;
         mem_we     <= 1'b0;
         halted     <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         mem_we     <= 1'b0;
         instr_done <= 1'b0;
         unique case (state)
            S_FETCH: begin
               if (run) state <= S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
               ir    <= mem_rdata;
               state <= S_DECODE;
               // HALT completes in DECODE, so its done pulse is armed from the fetched word.
               if (mem_rdata[15:12] == OP_HALT) instr_done <= 1'b1;
            end
            S_DECODE: begin
               mar <= operand;
               pc  <= pc_inc;
               case (opcode)
                  OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                     state <= S_EXEC_READ;
                  end
                  OP_STORE: begin
                     state      <= S_EXEC_WRITE;
                     mem_we     <= 1'b1;
                     instr_done <= 1'b1;
                  end
                  OP_HALT: begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end
                  default: begin
                     state      <= S_EXEC;
                     instr_done <= 1'b1;
                  end
               endcase
            end
            S_EXEC_READ: begin
               state <= S_EXEC_WAIT;
            end
            S_EXEC_WAIT: begin
               mbr        <= mem_rdata;
               state      <= S_EXEC;
               instr_done <= 1'b1;
            end
            S_EXEC: begin
               state <= S_FETCH;
               case (opcode)
                  OP_LOAD:                                   ac <= mbr;
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                  OP_SHL, OP_SHR:                            ac <= alu_result;
                  OP_JUMP:                                   pc <= operand;
                  OP_JUMPZ:  if (ac_zero)                    pc <= operand;
                  // pc already points past this instruction, so one more step skips the next.
                  OP_SKIPZ:  if (ac_zero)                    pc <= pc_inc;
                  OP_SKIPNZ: if (!ac_zero)                   pc <= pc_inc;
                  OP_CLEAR:                                  ac <= 16'h0000;
                  default: ;
               endcase
            end
            S_EXEC_WRITE: begin
               state <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
         endcase
      end
   end

endmodule
